mult_issue: RTL and testbench

Issue/launch stage directly upstream of the sequential unsigned multiplier (multu).
- Accepts operand pairs over a valid/ready request channel and latches them.
- Drives the multiplier's a/b/doMult/reset inputs and waits for mult_done.
- Captures the 32-bit product and holds it on a valid/ready response channel until consumed.
- A watchdog aborts a hung multiply and returns an error response.

---
 rtl/mult_issue.sv | 128 ++++++++++++
 tb/tb_mult_issue.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_issue.sv
// Issue/launch stage for the sequential multu multiplier: latches operands, pulses doMult,
// waits for done with a watchdog, and holds the product on a response channel.
// Optional build macro MULT_ZERO_BYPASS_EN: zero operands skip the multiplier.
module mult_issue #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  output logic        mult_start,
  output logic        mult_reset,
  input  logic        mult_done,
  input  logic [31:0] mult_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    RESP
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                err_q, err_d;
  logic                mrst_q;
  logic                abort;

  // State and datapath registers; multu is reset alongside this block and on abort
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      mrst_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      err_q   <= err_d;
      mrst_q  <= abort;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    err_d   = err_q;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          a_d     = req_a;
          b_d     = req_b;
          state_d = START;
`ifdef MULT_ZERO_BYPASS_EN
          if ((req_a == '0) || (req_b == '0)) begin
            data_d  = '0;
            err_d   = 1'b0;
            state_d = RESP;
          end
`endif
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // done in the first WAIT cycle may be left over from the previous op
        if (mult_done && (cnt_q != '0)) begin
          data_d  = mult_out;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          data_d  = '0;
          err_d   = 1'b1;
          abort   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready  = (state_q == IDLE) && !reset;
  assign mult_start = (state_q == START);
  assign rsp_valid  = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign mult_a     = a_q;
  assign mult_b     = b_q;
  assign mult_reset = mrst_q;
  assign rsp_data   = data_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_mult_issue.sv
// Scoreboard bench for mult_issue with a behavioural multu model that can hang,
// present a stale done level, or supply a fixed product.
module tb_mult_issue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [31:0] mult_a, mult_b;
  logic        mult_start, mult_reset;
  logic        mult_done;
  logic [31:0] mult_out;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;

  int nvec = 0;
  int nerr = 0;
  logic [32:0] sb[$];

  // multu model controls
  int          mdl_lat  = 32;
  logic        mdl_hang = 1'b0;
  logic        ovr_done = 1'b0;
  logic        fix_en   = 1'b0;
  logic [31:0] fix_out  = '0;
  logic        m_run  = 1'b0;
  logic        m_done = 1'b0;
  int          m_cnt  = 0;
  logic [31:0] m_prod = '0;

  always #5 clk = ~clk;

  mult_issue #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .mult_a(mult_a), .mult_b(mult_b), .mult_start(mult_start), .mult_reset(mult_reset),
    .mult_done(mult_done), .mult_out(mult_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy)
  );

  // Behavioural multu: done is a level held until the next start or reset
  always @(posedge clk) begin
    if (mult_reset === 1'b1) begin
      m_run  <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
    end else if (mult_start === 1'b1) begin
      m_run  <= 1'b1;
      m_done <= 1'b0;
      m_cnt  <= 0;
      m_prod <= 32'(mult_a * mult_b);
    end else if (m_run) begin
      if (m_cnt == mdl_lat - 1) begin
        m_run  <= 1'b0;
        m_done <= 1'b1;
      end
      m_cnt <= m_cnt + 1;
    end
  end

  assign mult_done = ovr_done | (m_done & ~mdl_hang);
  assign mult_out  = ovr_done ? 32'h1234_5678 : (fix_en ? fix_out : m_prod);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!req_ready && n < 100) begin
      tick();
      n++;
    end
    check("req_ready_wait", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    tick();
    req_valid = 1'b0;
  endtask

  // Waits for rsp_valid; reports whether done was high in the cycle before it rose
  task automatic wait_rsp(input string tag, output logic done_prev);
    int cyc = 0;
    done_prev = 1'b0;
    while (!rsp_valid && cyc < 300) begin
      done_prev = mult_done;
      tick();
      cyc++;
    end
    check({tag, "_rsp_seen"}, 32'(rsp_valid), 32'd1);
  endtask

  task automatic pop_check(input string tag);
    logic [32:0] e;
    check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_data"}, rsp_data, e[31:0]);
      check({tag, "_err"}, 32'(rsp_err), 32'(e[32]));
    end
  endtask

  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_busy_drop"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=hang exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic dp;
    int   cyc;
    int   mrc;
    int   seen;

    // Reset with a request pending
    req_valid = 1'b1;
    req_a     = 32'd99;
    req_b     = 32'd3;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_mult_start", 32'(mult_start), 32'd0);
      check("rst_mult_reset", 32'(mult_reset), 32'd1);
    end
    reset     = 1'b0;
    req_valid = 1'b0;
    #1;
    check("post_rst_req_ready", 32'(req_ready), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_mult_a", mult_a, 32'd0);

    // Basic 2x5
    sb.push_back({1'b0, 32'd10});
    send(32'd2, 32'd5);
    check("basic_start", 32'(mult_start), 32'd1);
    check("basic_mult_a", mult_a, 32'd2);
    check("basic_mult_b", mult_b, 32'd5);
    tick();
    check("basic_start_1cyc", 32'(mult_start), 32'd0);
    wait_rsp("basic", dp);
    check("basic_latency", 32'(dp), 32'd1);
    pop_check("basic");

    // Backpressure with a new request waiting
    req_valid = 1'b1;
    req_a     = 32'd7;
    req_b     = 32'd1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_data", rsp_data, 32'd10);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_mult_a", mult_a, 32'd2);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_busy_drop", 32'(busy), 32'd0);
    check("bp_no_same_cycle", mult_a, 32'd2);
    sb.push_back({1'b0, 32'd7});
    tick();
    req_valid = 1'b0;
    check("bp2_start", 32'(mult_start), 32'd1);
    check("bp2_mult_a", mult_a, 32'd7);
    wait_rsp("bp2", dp);
    pop_check("bp2");
    handshake("bp2");

    // Stale done through START and the first WAIT cycle
    ovr_done = 1'b1;
    fix_en   = 1'b1;
    fix_out  = 32'hFFFF_FFFE;
    sb.push_back({1'b0, 32'hFFFF_FFFE});
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("stale_start", 32'(mult_start), 32'd1);
    tick();
    tick();
    ovr_done = 1'b0;
    check("stale_ignored", 32'(rsp_valid), 32'd0);
    wait_rsp("stale", dp);
    pop_check("stale");
    handshake("stale");
    fix_en = 1'b0;

    // Timeout: multu never raises done
    mdl_hang = 1'b1;
    sb.push_back({1'b1, 32'd0});
    send(32'd9, 32'd9);
    cyc = 0;
    mrc = 0;
    while (!rsp_valid && cyc < 200) begin
      tick();
      cyc++;
      if (mult_reset) mrc++;
    end
    check("to_cycles", 32'(cyc), 32'd65);
    pop_check("to");
    for (int i = 0; i < 3; i++) begin
      tick();
      if (mult_reset) mrc++;
    end
    check("to_mult_reset_1cyc", 32'(mrc), 32'd1);
    handshake("to");
    mdl_hang = 1'b0;
    sb.push_back({1'b0, 32'd12});
    send(32'd3, 32'd4);
    wait_rsp("after_to", dp);
    pop_check("after_to");
    handshake("after_to");

    // Reset in the middle of WAIT
    send(32'd5, 32'd6);
    tick();
    for (int i = 0; i < 10; i++) tick();
    check("midrst_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_mult_reset", 32'(mult_reset), 32'd1);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (rsp_valid) seen++;
    end
    check("midrst_no_rsp", 32'(seen), 32'd0);

`ifdef MULT_ZERO_BYPASS_EN
    // Zero operand skips the multiplier
    sb.push_back({1'b0, 32'd0});
    send(32'd7, 32'd0);
    check("byp_no_start", 32'(mult_start), 32'd0);
    check("byp_rsp_valid", 32'(rsp_valid), 32'd1);
    check("byp_mult_a", mult_a, 32'd7);
    pop_check("byp");
    handshake("byp");
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
